csr_rmw: RTL and testbench

Read-modify-write sequencer that sits directly upstream of the core's CSR register file and executes Zicsr instructions against it. It accepts one CSR request per instruction and returns the old CSR value to the writeback path. It drives a single-cycle write strobe into the register file, and holds the architected cycle/instret counters.

---
 rtl/csr_rmw.sv | 171 +++++++++++++++++
 tb/tb_csr_rmw.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_rmw.sv
// csr_rmw: Zicsr read-modify-write sequencer sitting in front of the CSR register file.
// Ports: req_* (request in, req_ready out), rsp_* (old value / illegal flag),
//        csr_* (addr/we/wdata out, asynchronous rdata in), instret_inc (retire pulse).
// Macro CSR_COUNTERS_EN maps read-only 64-bit cycle/instret counters at 0xC00/0xC02 (+0xB00/0xB02 aliases).
module csr_rmw #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_func,
    input  logic [11:0]       req_addr,
    input  logic [DWIDTH-1:0] req_rs1,
    input  logic [4:0]        req_zimm,
    input  logic              req_rs1_is_x0,
    input  logic              instret_inc,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    output logic [11:0]       csr_addr,
    output logic              csr_we,
    output logic [DWIDTH-1:0] csr_wdata,
    input  logic [DWIDTH-1:0] csr_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        func_q, func_d;
    logic [DWIDTH-1:0] opnd_q, opnd_d;
    logic              nowr_q, nowr_d;
    logic [11:0]       csr_addr_q, csr_addr_d;
    logic [DWIDTH-1:0] csr_wdata_q, csr_wdata_d;
    logic              csr_we_q, csr_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              is_cnt;
    logic [DWIDTH-1:0] cnt_val;
    logic [DWIDTH-1:0] old_val;
    logic [DWIDTH-1:0] new_val;
    logic              set_clr;

`ifdef CSR_COUNTERS_EN
    logic [63:0] cyc_q, cyc_d;
    logic [63:0] inst_q, inst_d;
    logic [63:0] cnt_sel;

    // addr[7] selects the high half, addr[1] selects instret over cycle
    always_comb begin
        is_cnt  = (csr_addr_q[11:8] == 4'hC || csr_addr_q[11:8] == 4'hB)
                  && csr_addr_q[6:2] == 5'd0 && !csr_addr_q[0];
        cnt_sel = csr_addr_q[1] ? inst_q : cyc_q;
        cnt_val = csr_addr_q[7] ? DWIDTH'(cnt_sel[63:32])
                                : DWIDTH'(cnt_sel[31:0]);
        cyc_d   = cyc_q + 64'd1;
        inst_d  = inst_q + {63'd0, instret_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            inst_q <= inst_d;
        end
    end
`else
    logic unused_instret;
    assign unused_instret = instret_inc;
    assign is_cnt  = 1'b0;
    assign cnt_val = '0;
`endif

    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        opnd_d      = opnd_q;
        nowr_d      = nowr_q;
        csr_addr_d  = csr_addr_q;
        csr_wdata_d = csr_wdata_q;
        csr_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        old_val     = '0;
        new_val     = '0;
        set_clr     = req_func[1];
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    func_d     = req_func[1:0];
                    csr_addr_d = req_addr;
                    opnd_d     = req_func[2] ? DWIDTH'(req_zimm) : req_rs1;
                    // set/clear with a zero source never writes
                    nowr_d     = (req_func[1:0] == 2'b00)
                                 || (set_clr && (req_func[2] ? (req_zimm == 5'd0)
                                                             : req_rs1_is_x0));
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                old_val = is_cnt ? cnt_val : csr_rdata;
                unique case (func_q)
                    2'b01:   new_val = opnd_q;
                    2'b10:   new_val = old_val | opnd_q;
                    2'b11:   new_val = old_val & ~opnd_q;
                    default: new_val = old_val;
                endcase
                csr_wdata_d = new_val;
                csr_we_d    = !nowr_q && !is_cnt;
                rsp_valid_d = 1'b1;
                rsp_data_d  = old_val;
                rsp_err_d   = (func_q == 2'b00);
                state_d     = S_WR;
            end
            S_WR: begin
                csr_addr_d  = '0;
                csr_wdata_d = '0;
                state_d     = S_IDLE;
            end
            default: begin
                csr_addr_d  = '0;
                csr_wdata_d = '0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            func_q      <= '0;
            opnd_q      <= '0;
            nowr_q      <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            csr_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            opnd_q      <= opnd_d;
            nowr_q      <= nowr_d;
            csr_addr_q  <= csr_addr_d;
            csr_wdata_q <= csr_wdata_d;
            csr_we_q    <= csr_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign csr_addr  = csr_addr_q;
    assign csr_we    = csr_we_q;
    assign csr_wdata = csr_wdata_q;

endmodule

// File: tb/tb_csr_rmw.sv
// tb_csr_rmw: directed bench for csr_rmw with a behavioural CSR register file.
// Expected values are hand-computed constants; counter values come from a bench edge counter.
module tb_csr_rmw;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_func;
    logic [11:0] req_addr;
    logic [31:0] req_rs1;
    logic [4:0]  req_zimm;
    logic        req_rs1_is_x0;
    logic        instret_inc;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf [4096];
    logic        ld;
    logic [11:0] ld_addr;
    logic [31:0] ld_val;
    int          ecnt;

    csr_rmw #(.DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_addr(req_addr),
        .req_rs1(req_rs1), .req_zimm(req_zimm),
        .req_rs1_is_x0(req_rs1_is_x0), .instret_inc(instret_inc),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign csr_rdata = rf[csr_addr];

    always @(posedge clk) begin
        if (ld) rf[ld_addr] <= ld_val;
        else if (csr_we) rf[csr_addr] <= csr_wdata;
    end

    // posedges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        ld = 1'b1; ld_addr = a; ld_val = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic [2:0] f, input logic [11:0] a,
                          input logic [31:0] rs1, input logic [4:0] zi, input logic x0,
                          input logic ewe, input logic [31:0] eold_in, input logic eerr,
                          input logic [31:0] ewd, input logic use_cyc);
        logic [31:0] eold;
        @(negedge clk);
        for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
        chk({tag, ".ready_wait"}, 64'(req_ready), 64'd1);
        eold = use_cyc ? 32'(ecnt + 1) : eold_in;
        req_valid = 1'b1; req_func = f; req_addr = a;
        req_rs1 = rs1; req_zimm = zi; req_rs1_is_x0 = x0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_func = 3'b000; req_addr = 12'h000; req_rs1 = 32'h0;
        chk({tag, ".rd_ready"}, 64'(req_ready), 64'd0);
        chk({tag, ".rd_vld"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".rd_we"}, 64'(csr_we), 64'd0);
        chk({tag, ".rd_addr"}, 64'(csr_addr), 64'(a));
        @(posedge clk); #1;
        chk({tag, ".wr_vld"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".wr_we"}, 64'(csr_we), 64'(ewe));
        chk({tag, ".wr_old"}, 64'(rsp_data), 64'(eold));
        chk({tag, ".wr_err"}, 64'(rsp_err), 64'(eerr));
        chk({tag, ".wr_addr"}, 64'(csr_addr), 64'(a));
        if (ewe) chk({tag, ".wr_wdata"}, 64'(csr_wdata), 64'(ewd));
        @(posedge clk); #1;
        chk({tag, ".id_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".id_vld"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".id_we"}, 64'(csr_we), 64'd0);
        chk({tag, ".id_addr"}, 64'(csr_addr), 64'd0);
        chk({tag, ".id_wdata"}, 64'(csr_wdata), 64'd0);
        chk({tag, ".id_hold"}, 64'(rsp_data), 64'(eold));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_func = 3'b000; req_addr = 12'h000;
        req_rs1 = 32'h0; req_zimm = 5'd0; req_rs1_is_x0 = 1'b0; instret_inc = 1'b0;
        ld = 1'b0; ld_addr = 12'h000; ld_val = 32'h0;
        preload(12'h340, 32'h12345678);
        preload(12'h341, 32'h00000000);
        preload(12'hC00, 32'hA5A5A5A5);
        preload(12'h000, 32'h00000000);
        #1;
        chk("rst.we", 64'(csr_we), 64'd0);
        chk("rst.vld", 64'(rsp_valid), 64'd0);
        chk("rst.data", 64'(rsp_data), 64'd0);
        chk("rst.err", 64'(rsp_err), 64'd0);
        chk("rst.addr", 64'(csr_addr), 64'd0);
        chk("rst.wdata", 64'(csr_wdata), 64'd0);
        chk("rst.ready", 64'(req_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        do_req("rw340", 3'b001, 12'h340, 32'hDEADBEEF, 5'd0, 1'b0,
               1'b1, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0);
        do_req("rs340", 3'b010, 12'h340, 32'h0000000F, 5'd0, 1'b0,
               1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
        chk("rf340.a", 64'(rf[12'h340]), 64'hDEADBEEF);
        do_req("rc340", 3'b011, 12'h340, 32'h000000FF, 5'd0, 1'b0,
               1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBE00, 1'b0);
        do_req("rci340", 3'b111, 12'h340, 32'hFFFFFFFF, 5'h10, 1'b0,
               1'b1, 32'hDEADBE00, 1'b0, 32'hDEADBE00, 1'b0);
        chk("rf340.b", 64'(rf[12'h340]), 64'hDEADBE00);
        do_req("rs_x0", 3'b010, 12'h340, 32'h0000FFFF, 5'd0, 1'b1,
               1'b0, 32'hDEADBE00, 1'b0, 32'h0, 1'b0);
        do_req("rsi_z0", 3'b110, 12'h340, 32'hFFFFFFFF, 5'd0, 1'b0,
               1'b0, 32'hDEADBE00, 1'b0, 32'h0, 1'b0);
        do_req("ill100", 3'b100, 12'h340, 32'hFFFFFFFF, 5'h1F, 1'b0,
               1'b0, 32'hDEADBE00, 1'b1, 32'h0, 1'b0);
        do_req("ill000", 3'b000, 12'h340, 32'h00000001, 5'd1, 1'b0,
               1'b0, 32'hDEADBE00, 1'b1, 32'h0, 1'b0);
        chk("rf340.c", 64'(rf[12'h340]), 64'hDEADBE00);
        do_req("rwi341", 3'b101, 12'h341, 32'hFFFFFFFF, 5'h15, 1'b1,
               1'b1, 32'h00000000, 1'b0, 32'h00000015, 1'b0);
        do_req("rw_x0", 3'b001, 12'h341, 32'h00000000, 5'd0, 1'b1,
               1'b1, 32'h00000015, 1'b0, 32'h00000000, 1'b0);
        do_req("rsi341", 3'b110, 12'h341, 32'h0, 5'h03, 1'b0,
               1'b1, 32'h00000000, 1'b0, 32'h00000003, 1'b0);
        do_req("rci341", 3'b111, 12'h341, 32'h0, 5'h01, 1'b0,
               1'b1, 32'h00000003, 1'b0, 32'h00000002, 1'b0);
        chk("rf341", 64'(rf[12'h341]), 64'h00000002);

`ifdef CSR_COUNTERS_EN
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instret_inc = (i % 2 == 0) && (i < 8);
            @(negedge clk);
        end
        instret_inc = 1'b0;
        do_req("inst_lo", 3'b010, 12'hC02, 32'h0, 5'd0, 1'b1,
               1'b0, 32'd4, 1'b0, 32'h0, 1'b0);
        do_req("inst_hi", 3'b010, 12'hC82, 32'h0, 5'd0, 1'b1,
               1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
        do_req("inst_alias", 3'b110, 12'hB02, 32'h0, 5'd0, 1'b0,
               1'b0, 32'd4, 1'b0, 32'h0, 1'b0);
        do_req("cyc_lo", 3'b010, 12'hC00, 32'h0, 5'd0, 1'b1,
               1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        do_req("cyc_alias", 3'b010, 12'hB00, 32'h0, 5'd0, 1'b1,
               1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        do_req("cyc_hi", 3'b010, 12'hC80, 32'h0, 5'd0, 1'b1,
               1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
        do_req("cyc_rw", 3'b001, 12'hC00, 32'h00000005, 5'd0, 1'b0,
               1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rfC00", 64'(rf[12'hC00]), 64'hA5A5A5A5);
        instret_inc = 1'b1;
`else
        do_req("c00_rw", 3'b001, 12'hC00, 32'h00000005, 5'd0, 1'b0,
               1'b1, 32'hA5A5A5A5, 1'b0, 32'h00000005, 1'b0);
        chk("rfC00", 64'(rf[12'hC00]), 64'h00000005);
`endif

        // reset while the request sits in RD
        @(negedge clk);
        req_valid = 1'b1; req_func = 3'b001; req_addr = 12'h340;
        req_rs1 = 32'h0BADF00D; req_rs1_is_x0 = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        instret_inc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rrd.vld", 64'(rsp_valid), 64'd0);
            chk("rrd.we", 64'(csr_we), 64'd0);
            chk("rrd.ready", 64'(req_ready), 64'd1);
            chk("rrd.addr", 64'(csr_addr), 64'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        chk("rrd.rf", 64'(rf[12'h340]), 64'hDEADBE00);
        do_req("after_rst", 3'b010, 12'h340, 32'h0, 5'd0, 1'b1,
               1'b0, 32'hDEADBE00, 1'b0, 32'h0, 1'b0);
`ifdef CSR_COUNTERS_EN
        do_req("inst_rst", 3'b010, 12'hC02, 32'h0, 5'd0, 1'b1,
               1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
        do_req("cyc_rst", 3'b010, 12'hC00, 32'h0, 5'd0, 1'b1,
               1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
